cnt_seq_monitor: RTL and testbench
==================================

// Module: cnt_seq_monitor
// PURPOSE
//  Downstream checker for the 3-bit fancy counter (even values dwell EVEN_DWELL
//  cycles, odd values ODD_DWELL cycles, 7 wraps to 0).
//  Samples the counter value every clock and tracks the current value and its
//  run length. Flags skipped values and wrong dwell times, and counts full wraps.
//  Raises a lock indication once the sequence has been clean for LOCK_N transitions.
// PARAMETERS
//  EVEN_DWELL  5  required run length (cycles) of each even value
//  ODD_DWELL   1  required run length (cycles) of each odd value
//  LOCK_N      8  consecutive clean checked transitions before locked=1
//  WRAP_W      8  width of wrap counter
// PORTS
//  clk         in   1       single clock; all state on posedge
//  rst         in   1       asynchronous, active-high reset
//  cnt_in      in   3       counter value from fancy counter (registered upstream)
//  cur_val     out  3       value currently being tracked (cnt_q)
//  run_len     out  4       edges cur_val has been sampled; saturates at 15
//  trans_pulse out  1       1-cycle pulse on a clean checked transition
//  wrap_pulse  out  1       1-cycle pulse on clean checked 7->0 transition
//  wrap_cnt    out  WRAP_W  number of wrap_pulses, modulo 2^WRAP_W
//  locked      out  1       LOCK_N clean transitions seen since last error/reset
//  err_pulse   out  1       1-cycle pulse on any detected violation
//  err_code    out  2       last error: 00 none, 01 skip, 10 underdwell, 11 overdwell
//  err_sticky  out  1       set on first error; cleared only by rst
// BEHAVIOUR
//  - rst=1: all outputs 0 immediately, FSM=SYNC, cnt_q=0, run_len=0, clean_cnt=0.
//  - All outputs registered; a check made on edge N is visible after edge N.
//  - Every edge: if cnt_in==cnt_q then run_len<=sat15(run_len+1);
//    else cnt_q<=cnt_in, run_len<=1 (a "transition").
//  - dwell(v) = EVEN_DWELL if v[0]==0, else ODD_DWELL.
//  - FSM SYNC: no checks; on first transition -> TRACK (that transition unchecked,
//    no trans_pulse, no wrap_pulse).
//  - FSM TRACK, on transition from cnt_q to cnt_in:
//    skip if cnt_in != cnt_q+1 (mod 8); underdwell if run_len != dwell(cnt_q).
//    Both true -> report skip only. Clean -> trans_pulse=1, clean_cnt++ (sat LOCK_N).
//    Clean 7->0 additionally wrap_pulse=1, wrap_cnt++ (wraps modulo 2^WRAP_W).
//  - FSM TRACK, no transition: overdwell if run_len==dwell(cnt_q), i.e. the sample
//    would exceed the required dwell.
//  - Any error: err_pulse=1 for one cycle, err_code<=code, err_sticky<=1,
//    clean_cnt<=0, locked<=0, FSM->SYNC. run_len/cnt_q still update per rule above.
//  - Errors in SYNC are impossible by construction, so there is no repeated flagging
//    of one overlong run.
//  - locked<=1 on the edge clean_cnt reaches LOCK_N; held until error or rst.
//  - wrap_cnt and err_code survive errors; only rst clears them.
//  - rst mid-run: immediate async clear. First transition after release is unchecked.
// TESTING
//  1. rst released with ideal upstream (0x5,1,2x5,3,...): transitions at edges
//     6,7,12,13,18,19,24,25,30. Edge 6 is unchecked. wrap_pulse and wrap_cnt=1 after
//     edge 25. locked=1 after edge 30. err_sticky stays 0.
//  2. Skip: locked, hold 2 for 5 edges, then drive 4 -> err_pulse=1, err_code=01,
//     err_sticky=1, locked=0. Next transition unchecked.
//  3. Underdwell: in TRACK, hold 4 for 3 edges then 5 -> err_code=10, err_pulse=1
//     for exactly one cycle.
//  4. Overdwell: in TRACK, hold 3 for 2 edges -> err_code=11 after 2nd sample.
//     A further hold of 3 gives no second err_pulse.
//  5. Async reset: locked=1, wrap_cnt=3; assert rst between edges -> all outputs 0
//     before next edge. After release, test 1 repeats exactly.
//  6. WRAP_W=2, 4 clean wraps -> wrap_cnt 1,2,3,0. Each wrap gives exactly one
//     wrap_pulse.

Source files
------------

// File: rtl/cnt_seq_monitor.sv
// cnt_seq_monitor
//   Downstream checker for the 3-bit fancy counter. Even values should dwell
//   EVEN_DWELL cycles, odd values ODD_DWELL cycles, and 7 wraps to 0.
//   The monitor samples cnt_in every clock and tracks the current value and how
//   long it has been held. It flags skipped values, short dwells and long dwells,
//   and counts clean wraps. It asserts locked after LOCK_N clean transitions in a row.
//
// Ports
//   clk          clock, all state on posedge
//   rst          asynchronous active-high reset
//   cnt_in[2:0]  sampled counter value (registered upstream)
//   cur_val[2:0] value currently being tracked
//   run_len[3:0] number of samples of cur_val, saturating at 15
//   trans_pulse  one-cycle pulse on a clean checked transition
//   wrap_pulse   one-cycle pulse on a clean checked 7->0 transition
//   wrap_cnt     count of wrap pulses, modulo 2^WRAP_W
//   locked       LOCK_N clean transitions seen since the last error or reset
//   err_pulse    one-cycle pulse on any violation
//   err_code     last error: 00 none, 01 skip, 10 underdwell, 11 overdwell
//   err_sticky   set on the first error, cleared only by rst
module cnt_seq_monitor #(
  parameter int EVEN_DWELL = 5,
  parameter int ODD_DWELL  = 1,
  parameter int LOCK_N     = 8,
  parameter int WRAP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cnt_in,
  output logic [2:0]        cur_val,
  output logic [3:0]        run_len,
  output logic              trans_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output logic              err_sticky
);

  localparam int CW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] LOCK_C = CW'(LOCK_N);
  localparam logic [3:0]    EVEN_D = 4'(EVEN_DWELL);
  localparam logic [3:0]    ODD_D  = 4'(ODD_DWELL);

  typedef enum logic {SYNC, TRACK} state_t;

  state_t        state;
  logic [CW-1:0] clean_cnt;

  logic       is_trans, skip, under, over, err_now, clean, wrap_now;
  logic [3:0] req_dwell;
  logic [1:0] code;

  // The checks are made against the value being left (cur_val) and its run length.
  always_comb begin
    is_trans  = (cnt_in != cur_val);
    req_dwell = cur_val[0] ? ODD_D : EVEN_D;
    skip      = is_trans && (cnt_in != cur_val + 3'd1);
    under     = is_trans && (run_len != req_dwell);
    // A run that has already reached its required length and is sampled again
    // would be too long.
    over      = !is_trans && (run_len == req_dwell);
    err_now   = (state == TRACK) && (skip || under || over);
    clean     = (state == TRACK) && is_trans && !skip && !under;
    wrap_now  = clean && (cnt_in == 3'd0);
    // A skip takes priority over an underdwell on the same transition.
    if (skip)       code = 2'b01;
    else if (under) code = 2'b10;
    else            code = 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC;
      clean_cnt   <= '0;
      cur_val     <= '0;
      run_len     <= '0;
      trans_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      wrap_cnt    <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_code    <= 2'b00;
      err_sticky  <= 1'b0;
    end else begin
      if (is_trans) begin
        cur_val <= cnt_in;
        run_len <= 4'd1;
      end else if (run_len != 4'd15) begin
        run_len <= run_len + 4'd1;
      end

      trans_pulse <= clean;
      wrap_pulse  <= wrap_now;
      err_pulse   <= err_now;
      if (wrap_now) wrap_cnt <= wrap_cnt + 1'b1;

      case (state)
        // The first transition after reset or an error is taken as a
        // resynchronisation point and is not checked.
        SYNC: if (is_trans) state <= TRACK;
        TRACK: begin
          if (err_now) begin
            state      <= SYNC;
            err_code   <= code;
            err_sticky <= 1'b1;
            clean_cnt  <= '0;
            locked     <= 1'b0;
          end else if (clean) begin
            if (clean_cnt != LOCK_C) clean_cnt <= clean_cnt + 1'b1;
            if (clean_cnt >= LOCK_C - 1'b1) locked <= 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_monitor.sv
module tb_cnt_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] cnt_in = 3'd0;

  logic [2:0] cur_val,  cur_val2;
  logic [3:0] run_len,  run_len2;
  logic       trans_pulse, trans_pulse2, wrap_pulse, wrap_pulse2;
  logic [7:0] wrap_cnt;
  logic [1:0] wrap_cnt2;
  logic       locked, locked2, err_pulse, err_pulse2, err_sticky, err_sticky2;
  logic [1:0] err_code, err_code2;

  always #5 clk = ~clk;

  cnt_seq_monitor dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in),
    .cur_val(cur_val), .run_len(run_len), .trans_pulse(trans_pulse),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .locked(locked),
    .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky)
  );

  cnt_seq_monitor #(.WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in),
    .cur_val(cur_val2), .run_len(run_len2), .trans_pulse(trans_pulse2),
    .wrap_pulse(wrap_pulse2), .wrap_cnt(wrap_cnt2), .locked(locked2),
    .err_pulse(err_pulse2), .err_code(err_code2), .err_sticky(err_sticky2)
  );

  typedef struct {
    logic       arst;
    logic [2:0] cnt;
    logic [2:0] cur;
    logic [3:0] rl;
    logic       tp, wp;
    logic [7:0] wc;
    logic       lk, ep;
    logic [1:0] ec;
    logic       es;
    logic [1:0] wc2;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t ev;
  int checks = 0;
  int failures = 0;
  int edge_no = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @vec %0d: got %0h expected %0h", name, edge_no, act, exp);
    end
  endtask

  function automatic void add(logic [2:0] cnt, logic [2:0] cur, logic [3:0] rl,
                              logic tp, logic wp, logic [7:0] wc, logic lk,
                              logic ep, logic [1:0] ec, logic es);
    vec_t v;
    v.arst = 1'b0; v.cnt = cnt; v.cur = cur; v.rl = rl; v.tp = tp; v.wp = wp;
    v.wc = wc; v.lk = lk; v.ep = ep; v.ec = ec; v.es = es; v.wc2 = wc[1:0];
    vecs.push_back(v);
  endfunction

  function automatic void add_arst();
    vec_t v;
    v = '{default: '0};
    v.arst = 1'b1;
    vecs.push_back(v);
  endfunction

  // Ideal upstream: 0 x5, 1, 2 x5, 3, ... 7, 0 x5 ... (k counts edges from 1)
  function automatic logic [2:0] ideal(int k);
    int p;
    p = (k - 1) % 24;
    return ((p % 6) < 5) ? 3'(2 * (p / 6)) : 3'(2 * (p / 6) + 1);
  endfunction

  // Expected responses for a fresh-from-reset run of the ideal sequence.
  function automatic void gen_ideal(int n);
    logic [2:0] prev, cur;
    logic [3:0] rl;
    logic       tr, tp, wp;
    int         wc, clean;
    bit         seen;
    prev = 3'd0; wc = 0; clean = 0; seen = 0;
    for (int k = 1; k <= n; k++) begin
      cur = ideal(k);
      rl  = (((k - 1) % 6) < 5) ? 4'(((k - 1) % 6) + 1) : 4'd1;
      tr  = (cur != prev);
      tp  = tr && seen;
      if (tr) seen = 1;
      wp  = tp && (cur == 3'd0);
      if (wp) wc++;
      if (tp) clean++;
      add(cur, cur, rl, tp, wp, 8'(wc), clean >= 8, 1'b0, 2'b00, 1'b0);
      prev = cur;
    end
  endfunction

  // Scoreboard: expected record pushed when driven, compared after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      ev = sb.pop_front();
      edge_no++;
      chk("cur_val",     32'(cur_val),     32'(ev.cur));
      chk("run_len",     32'(run_len),     32'(ev.rl));
      chk("trans_pulse", 32'(trans_pulse), 32'(ev.tp));
      chk("wrap_pulse",  32'(wrap_pulse),  32'(ev.wp));
      chk("wrap_cnt",    32'(wrap_cnt),    32'(ev.wc));
      chk("locked",      32'(locked),      32'(ev.lk));
      chk("err_pulse",   32'(err_pulse),   32'(ev.ep));
      chk("err_code",    32'(err_code),    32'(ev.ec));
      chk("err_sticky",  32'(err_sticky),  32'(ev.es));
      chk("w2_wrap_pulse", 32'(wrap_pulse2), 32'(ev.wp));
      chk("w2_wrap_cnt",   32'(wrap_cnt2),   32'(ev.wc2));
    end
  end

  task automatic check_reset_zero();
    chk("rst_outputs",
        32'({cur_val, run_len, trans_pulse, wrap_pulse, wrap_cnt, locked,
             err_pulse, err_code, err_sticky}), 32'd0);
    chk("rst_outputs_w2",
        32'({cur_val2, run_len2, trans_pulse2, wrap_pulse2, wrap_cnt2, locked2,
             err_pulse2, err_code2, err_sticky2}), 32'd0);
  endtask

  initial begin
    // Reset, ideal run to 3 wraps, async reset mid-run, ideal run to 4 wraps.
    add_arst();
    gen_ideal(73);
    add_arst();
    gen_ideal(107);
    // Skip: 2 held 5 edges while locked, then 4.
    add(3'd4, 3'd4, 4'd1, 0, 0, 8'd4, 0, 1, 2'b01, 1);
    // Unchecked resync, then clean 3->4, hold 4 for 3 edges, 5 = underdwell.
    add(3'd3, 3'd3, 4'd1, 0, 0, 8'd4, 0, 0, 2'b01, 1);
    add(3'd4, 3'd4, 4'd1, 1, 0, 8'd4, 0, 0, 2'b01, 1);
    add(3'd4, 3'd4, 4'd2, 0, 0, 8'd4, 0, 0, 2'b01, 1);
    add(3'd4, 3'd4, 4'd3, 0, 0, 8'd4, 0, 0, 2'b01, 1);
    add(3'd5, 3'd5, 4'd1, 0, 0, 8'd4, 0, 1, 2'b10, 1);
    add(3'd5, 3'd5, 4'd2, 0, 0, 8'd4, 0, 0, 2'b10, 1);
    // Resync on 2, full dwell, clean 2->3, then 3 held twice = overdwell.
    add(3'd2, 3'd2, 4'd1, 0, 0, 8'd4, 0, 0, 2'b10, 1);
    for (int i = 2; i <= 5; i++)
      add(3'd2, 3'd2, 4'(i), 0, 0, 8'd4, 0, 0, 2'b10, 1);
    add(3'd3, 3'd3, 4'd1, 1, 0, 8'd4, 0, 0, 2'b10, 1);
    add(3'd3, 3'd3, 4'd2, 0, 0, 8'd4, 0, 1, 2'b11, 1);
    add(3'd3, 3'd3, 4'd3, 0, 0, 8'd4, 0, 0, 2'b11, 1);
    // Resync on 4, then 4->6 is both skip and underdwell: skip reported.
    add(3'd4, 3'd4, 4'd1, 0, 0, 8'd4, 0, 0, 2'b11, 1);
    add(3'd6, 3'd6, 4'd1, 0, 0, 8'd4, 0, 1, 2'b01, 1);
    add(3'd6, 3'd6, 4'd2, 0, 0, 8'd4, 0, 0, 2'b01, 1);
    // Long hold while unsynced: run_len saturates at 15, no error.
    for (int i = 0; i < 16; i++)
      add(3'd6, 3'd6, (3 + i > 15) ? 4'd15 : 4'(3 + i), 0, 0, 8'd4, 0, 0, 2'b01, 1);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].arst) begin
        #2 rst = 1'b1;
        cnt_in = 3'd0;
        #1 check_reset_zero();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        cnt_in = vecs[i].cnt;
        sb.push_back(vecs[i]);
        @(negedge clk);
      end
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
